// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues operands, observes status and results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one trial subtraction per clock, WIDTH steps.
// Results are published only at completion and held until the next one.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d_work;
  logic [WIDTH:0]   r_work;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   r_step;

  // One restoring step: shift in the next dividend bit, try subtracting D,
  // keep the difference only if it did not go negative.
  always_comb begin
    r_shift = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
    trial   = r_shift - {1'b0, d_work};
    q_step  = {q_work[WIDTH-2:0], ~trial[WIDTH]};
    r_step  = trial[WIDTH] ? r_shift : trial;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      q_work        <= '0;
      d_work        <= '0;
      r_work        <= '0;
      count         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_work <= bus.dividend;
            d_work <= bus.divisor;
            r_work <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          q_work <= q_step;
          r_work <= r_step;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            // Final step: publish results straight from the step logic.
            quotient_q    <= q_step;
            remainder_q   <= r_step[WIDTH-1:0];
            div_by_zero_q <= (d_work == '0);
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  vec_t vecs [8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at the first negedge after the start edge; returns the number of
  // clock edges until done is seen (-1 on timeout) and the busy cycle count.
  task automatic wait_done(output int n, output int busy_cnt);
    n = -1;
    busy_cnt = 0;
    for (int k = 0; k <= W + 4; k++) begin
      if (bus.done) begin
        n = k;
        check("busy_done_excl", {31'd0, bus.busy}, 0);
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    if (n < 0) check("done_timeout", 1, 0);
  endtask

  // Called at a negedge; pulses start for one edge, then scrambles operands.
  task automatic start_op(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = ~W'(a);
    bus.divisor  = ~W'(b);
  endtask

  task automatic check_results(input string tag, input int eq, input int er, input int ez);
    check({tag, "_q"}, {28'd0, bus.quotient}, eq);
    check({tag, "_r"}, {28'd0, bus.remainder}, er);
    check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, ez);
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input int eq, input int er, input int ez);
    int n, bc;
    start_op(a, b);
    wait_done(n, bc);
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_cycles"}, bc, W);
    check_results(tag, eq, er, ez);
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d cycles",
             a, b, bus.quotient, bus.remainder, bus.div_by_zero, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      if (bus.done) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, bc, cnt;
    vecs[0] = '{13,  3,  4, 1, 0};
    vecs[1] = '{15,  1, 15, 0, 0};
    vecs[2] = '{ 3,  9,  0, 3, 0};
    vecs[3] = '{ 0,  5,  0, 0, 0};
    vecs[4] = '{15, 15,  1, 0, 0};
    vecs[5] = '{ 7,  0, 15, 7, 1};
    vecs[6] = '{ 8,  2,  4, 0, 0};
    vecs[7] = '{ 6,  4,  1, 2, 0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_done", {31'd0, bus.done}, 0);
    check_results("reset", 0, 0, 0);

    // Directed table.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

    // Results hold after completion.
    run_op("hold", 13, 3, 4, 1, 0);
    for (int k = 0; k < 3; k++) begin
      check_results("hold_after", 4, 1, 0);
      check("hold_no_done", {31'd0, bus.done}, 0);
      @(negedge clk);
    end
    $display("hold: results kept for 3 idle cycles");

    // Start while busy is ignored.
    start_op(13, 3);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, bc);
    check("busy_start_latency", n, W - 2);
    check_results("busy_start", 4, 1, 0);
    @(negedge clk);
    count_dones(W + 3, cnt);
    check("busy_start_extra_done", cnt, 0);
    $display("busy start: q=%0d r=%0d, extra dones=%0d", bus.quotient, bus.remainder, cnt);

    // Back-to-back: new start held during the done cycle.
    start_op(13, 3);
    wait_done(n, bc);
    check("b2b_first_latency", n, W);
    check_results("b2b_first", 4, 1, 0);
    bus.start = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor = 4'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done_drop", {31'd0, bus.done}, 0);
    check("b2b_busy", {31'd0, bus.busy}, 1);
    wait_done(n, bc);
    check("b2b_second_latency", n, W);
    check("b2b_busy_cycles", bc, W);
    check_results("b2b_second", 2, 4, 0);
    $display("back-to-back: 14/5 -> q=%0d r=%0d after %0d cycles", bus.quotient, bus.remainder, n);
    @(negedge clk);

    // Exhaustive sweep against an arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq, er;
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        run_op($sformatf("sweep_%0d_%0d", a, b), a, b, eq, er, (b == 0) ? 1 : 0);
      end
    end

    // Reset in the middle of an operation.
    run_op("pre_abort", 15, 2, 7, 1, 0);
    start_op(13, 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 0);
    check_results("abort", 0, 0, 0);
    count_dones(W + 2, cnt);
    check("abort_no_done", cnt, 0);
    $display("abort: outputs cleared, dones after reset=%0d", cnt);
    run_op("post_abort", 6, 4, 1, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider, unsigned: quotient = dividend / divisor, remainder = dividend % divisor.
- Performs one trial subtraction per clock using the shared add/subtract datapath style.
- Inverse companion to the shift-and-add multiplier in the same arithmetic block set.
- Start/done handshake; results are held until the next completion.

Parameters:
WIDTH, 4, operand/result bit width (legal 2..16)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: results updated this cycle
quotient  output  WIDTH  last completed quotient
remainder  output  WIDTH  last completed remainder
div_by_zero  output  1  last completed operation had divisor=0

Behaviour:
- Reset is synchronous and active-high; single clock domain. Reset wins over every other input.
- Reset values:
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - FSM=IDLE; iteration counter=0; internal working registers=0.
- FSM states:
  - IDLE: wait for start.
  - CALC: iterate.
- IDLE -> CALC:
  - Trigger: start=1 at edge E0.
  - Latch dividend into shift register Q, divisor into D; clear partial remainder R (WIDTH+1 bits); counter=0; busy=1.
- CALC step, one per edge, WIDTH steps total:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
  - T = R' - {0,D}, computed in WIDTH+1 bits.
  - If T sign bit=0: R=T, Q[0]=1. Otherwise R=R' (restore), Q[0]=0.
  - Counter increments each step.
- CALC -> IDLE at edge E0+WIDTH (final step):
  - quotient=final Q; remainder=final R[WIDTH-1:0]; div_by_zero=(D==0).
  - busy=0; done=1 for exactly one cycle.
- Latency: done is high in the cycle following edge E0+WIDTH, i.e. WIDTH cycles after start is sampled.
- Results:
  - quotient, remainder and div_by_zero change only at completion; intermediate values are never visible.
  - They hold until the next completion or reset.
- Divide by zero:
  - No special path; same latency.
  - The algorithm yields quotient = all ones and remainder = dividend; div_by_zero=1.
- start while busy=1: ignored; operands not resampled; the running operation is unaffected.
- Back-to-back: start=1 in the done cycle (busy=0) is accepted. The next operation begins at that edge, and done drops the following cycle.
- Operand changes after sampling have no effect.
- Reset mid-CALC:
  - Operation is aborted; done is never asserted for it.
  - All outputs return to their reset values at that edge.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=4, reset 2 cycles, then dividend=13, divisor=3, start 1 cycle -> busy=1 for 4 cycles; done=1 on the 4th cycle after start with quotient=4, remainder=1, div_by_zero=0; outputs unchanged afterwards.
- Boundaries:
  - 15/1 -> q=15, r=0.
  - 3/9 -> q=0, r=3.
  - 0/5 -> q=0, r=0.
  - 15/15 -> q=1, r=0.
  - Each with done exactly 4 cycles after start.
- 7/0 -> done after 4 cycles; quotient=15, remainder=7, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
- 13/3 started, then start=1 with 9/4 on cycle 2 while busy -> ignored; single done with q=4, r=1; no second done.
- 13/3, then start with 14/5 held during the done cycle -> second done exactly 4 cycles later with q=2, r=4; done low in between.
- Exhaustive WIDTH=4 sweep, all 256 operand pairs -> every result matches a reference model; reset asserted at cycle 2 of a 13/3 operation -> all outputs 0, no done pulse, next 6/4 returns q=1, r=2.
